// File: rtl/serial_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmd_engine
// Description : Byte-stream command decoder between a UART rx/tx byte port and
//               the trigger/histogram logic. Decodes opcode + argument bytes
//               into an addressable config register file, snapshots histogram
//               channels for readout, drives one-cycle strobes, enforces an
//               inter-byte timeout and counts protocol errors.
//               Optional trailing XOR checksum on every response:
//               define SERIAL_CMD_CHECKSUM_EN to enable it.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cmd_engine #(
  parameter int                         NUM_HISTOS     = 8,
  parameter int                         HISTO_W        = 32,
  parameter int                         NUM_REGS       = 16,
  parameter int                         REG_W          = 32,
  parameter logic [NUM_REGS*REG_W-1:0]  REG_INIT       = {NUM_REGS*REG_W{1'b0}},
  parameter logic [7:0]                 FW_VERSION     = 8'd8,
  parameter int                         TIMEOUT_CYCLES = 1000000
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           rx_ready,
  input  logic [7:0]                     rx_data,
  input  logic                           tx_busy,
  output logic                           tx_start,
  output logic [7:0]                     tx_data,
  input  logic [NUM_HISTOS*HISTO_W-1:0]  histos,
  output logic                           hist_reset,
  output logic [NUM_REGS*REG_W-1:0]      regs,
  output logic [7:0]                     pulse_out,
  output logic [7:0]                     err_count,
  output logic                           busy
);

  localparam int c_reg_bytes  = REG_W / 8;
  localparam int c_hist_bits  = NUM_HISTOS * HISTO_W;
  localparam int c_hist_bytes = c_hist_bits / 8;
  localparam int c_resp_max   = (c_hist_bytes > c_reg_bytes) ? c_hist_bytes : c_reg_bytes;
  localparam int c_buf_w      = c_resp_max * 8;
`ifdef SERIAL_CMD_CHECKSUM_EN
  localparam int c_extra      = 1;
`else
  localparam int c_extra      = 0;
`endif
  localparam int c_idx_w      = $clog2(c_resp_max + c_extra + 1);
  // Longest argument list is the write: address byte plus a full register.
  localparam int c_cnt_w      = $clog2(c_reg_bytes + 2);
  // The timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int c_tmo_w      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_aw         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]         c_num_regs = 9'(NUM_REGS);

  localparam logic [7:0] c_op_ver   = 8'h00;
  localparam logic [7:0] c_op_wr    = 8'h01;
  localparam logic [7:0] c_op_rd    = 8'h02;
  localparam logic [7:0] c_op_hist  = 8'h03;
  localparam logic [7:0] c_op_pulse = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARGS     = 3'd1,
    S_EXEC     = 3'd2,
    S_SNAP     = 3'd3,
    S_SEND     = 3'd4,
    S_SEND_GAP = 3'd5
  } state_t;

  state_t               r_state;
  state_t               state_nxt;
  logic [7:0]           r_opcode;
  logic [c_cnt_w-1:0]   r_args_needed;
  logic [c_cnt_w-1:0]   r_arg_cnt;
  logic [c_tmo_w-1:0]   r_tmo;
  logic [7:0]           r_addr;
  logic [REG_W-1:0]     r_wdata;
  logic [c_buf_w-1:0]   r_buf;
  logic [c_idx_w-1:0]   r_len;
  logic [c_idx_w-1:0]   r_idx;
  logic [REG_W-1:0]     r_regs [NUM_REGS];

  logic                 w_err;
  logic                 w_addr_ok;
  logic [c_aw-1:0]      w_ridx;
  logic [c_idx_w-1:0]   w_total;
  logic [7:0]           w_tx_byte;

  assign w_addr_ok = ({1'b0, r_addr} < c_num_regs);
  assign w_ridx    = r_addr[c_aw-1:0];

  // Number of argument bytes that follow each opcode.
  function automatic logic [c_cnt_w-1:0] args_for(input logic [7:0] op);
    case (op)
      c_op_wr:             args_for = c_cnt_w'(c_reg_bytes + 1);
      c_op_rd, c_op_pulse: args_for = c_cnt_w'(1);
      default:             args_for = '0;
    endcase
  endfunction

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs[k*REG_W +: REG_W] = r_regs[k];
  end

`ifdef SERIAL_CMD_CHECKSUM_EN
  logic [7:0] r_csum;

  // The checksum byte goes out once every payload byte has been sent.
  assign w_total   = r_len + c_idx_w'(1);
  assign w_tx_byte = (r_idx == r_len) ? r_csum : r_buf[7:0];

  // Running XOR of payload bytes as they leave the buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_csum <= '0;
    end else if (r_state == S_EXEC) begin
      r_csum <= '0;
    end else if (r_state == S_SEND && !tx_busy) begin
      r_csum <= r_csum ^ r_buf[7:0];
    end
  end
`else
  assign w_total   = r_len;
  assign w_tx_byte = r_buf[7:0];
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= state_nxt;
  end

  // Next-state decode, error events and strobe outputs.
  always_comb begin
    state_nxt  = r_state;
    w_err      = 1'b0;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    hist_reset = 1'b0;
    pulse_out  = 8'h00;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (rx_ready) state_nxt = (args_for(rx_data) == '0) ? S_EXEC : S_ARGS;
      end
      S_ARGS: begin
        if (rx_ready) begin
          if (r_arg_cnt + c_cnt_w'(1) == r_args_needed) state_nxt = S_EXEC;
        end else if (r_tmo == c_tmo_last) begin
          state_nxt = S_IDLE;
          w_err     = 1'b1;
        end
      end
      S_EXEC: begin
        w_err = rx_ready;
        case (r_opcode)
          c_op_ver:  state_nxt = S_SEND;
          c_op_wr: begin
            state_nxt = S_IDLE;
            if (!w_addr_ok) w_err = 1'b1;
          end
          c_op_rd: begin
            state_nxt = S_SEND;
            if (!w_addr_ok) w_err = 1'b1;
          end
          c_op_hist: state_nxt = S_SNAP;
          c_op_pulse: begin
            state_nxt = S_IDLE;
            pulse_out = r_addr;
          end
          default: begin
            state_nxt = S_IDLE;
            w_err     = 1'b1;
          end
        endcase
      end
      S_SNAP: begin
        w_err      = rx_ready;
        hist_reset = 1'b1;
        state_nxt  = S_SEND;
      end
      S_SEND: begin
        w_err = rx_ready;
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data   = w_tx_byte;
          state_nxt = S_SEND_GAP;
        end
      end
      S_SEND_GAP: begin
        w_err     = rx_ready;
        state_nxt = (r_idx == w_total) ? S_IDLE : S_SEND;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command capture, argument assembly, timeout and response buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_opcode      <= '0;
      r_args_needed <= '0;
      r_arg_cnt     <= '0;
      r_tmo         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_buf         <= '0;
      r_len         <= '0;
      r_idx         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_ready) begin
            r_opcode      <= rx_data;
            r_args_needed <= args_for(rx_data);
            r_arg_cnt     <= '0;
            r_tmo         <= '0;
          end
        end
        S_ARGS: begin
          if (rx_ready) begin
            // First argument is the address/mask, the rest fill the register LSB first.
            if (r_arg_cnt == '0) r_addr  <= rx_data;
            else                 r_wdata <= REG_W'({rx_data, r_wdata} >> 8);
            r_arg_cnt <= r_arg_cnt + c_cnt_w'(1);
            r_tmo     <= '0;
          end else begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end
        end
        S_EXEC: begin
          r_idx <= '0;
          r_buf <= '0;
          case (r_opcode)
            c_op_ver: begin
              r_buf[7:0] <= FW_VERSION;
              r_len      <= c_idx_w'(1);
            end
            c_op_rd: begin
              if (w_addr_ok) r_buf[REG_W-1:0] <= r_regs[w_ridx];
              r_len <= c_idx_w'(c_reg_bytes);
            end
            c_op_hist: begin
              r_buf[c_hist_bits-1:0] <= histos;
              r_len                  <= c_idx_w'(c_hist_bytes);
            end
            default: ;
          endcase
        end
        S_SEND: begin
          if (!tx_busy) begin
            r_buf <= r_buf >> 8;
            r_idx <= r_idx + c_idx_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Config register file: loads REG_INIT on reset, written only in EXEC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= REG_INIT[k*REG_W +: REG_W];
    end else if (r_state == S_EXEC && r_opcode == c_op_wr && w_addr_ok) begin
      r_regs[w_ridx] <= r_wdata;
    end
  end

  // Saturating error counter; coincident error events count once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         err_count <= '0;
    else if (w_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_cmd_engine
// Description : Directed self-checking bench for serial_cmd_engine.
//               Follows SERIAL_CMD_CHECKSUM_EN to expect the trailing byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_cmd_engine;

  localparam int NH  = 8;
  localparam int HW  = 32;
  localparam int NR  = 16;
  localparam int RW  = 32;
  localparam int TMO = 100;

  function automatic logic [NR*RW-1:0] mk_init();
    logic [NR*RW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*RW +: RW] = 32'hA500_0000 | 32'(k * 3 + 1);
    return v;
  endfunction
  localparam logic [NR*RW-1:0] INIT = mk_init();

  logic              clk      = 1'b0;
  logic              rstn     = 1'b1;
  logic              rx_ready = 1'b0;
  logic [7:0]        rx_data  = 8'h00;
  logic              tx_busy  = 1'b0;
  logic [NH*HW-1:0]  histos   = '0;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              hist_reset;
  logic [NR*RW-1:0]  regs;
  logic [7:0]        pulse_out;
  logic [7:0]        err_count;
  logic              busy;

  serial_cmd_engine #(
    .NUM_HISTOS(NH), .HISTO_W(HW), .NUM_REGS(NR), .REG_W(RW),
    .REG_INIT(INIT), .FW_VERSION(8'd8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .histos(histos), .hist_reset(hist_reset), .regs(regs),
    .pulse_out(pulse_out), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] txq[$];
  int         txc[$];
  logic [7:0] expq[$];
  logic [RW-1:0] exp_regs[NR];
  int         hr_n = 0, hr_cyc = -1, pl_n = 0, bcnt = 0, rx_cyc = 0;
  logic [7:0] pl_val = 8'h00;
  bit         busy_mode = 1'b0;

  // UART side: record transmitted bytes and strobes; optionally stretch tx_busy.
  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
    end
    if (hist_reset) begin
      hr_n++;
      hr_cyc = cyc;
    end
    if (pulse_out != 8'h00) begin
      pl_n++;
      pl_val = pulse_out;
    end
    if (busy_mode) begin
      if (tx_start)      bcnt = 50;
      else if (bcnt > 0) bcnt--;
    end else begin
      bcnt = 0;
    end
    tx_busy = (bcnt != 0);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < NR; k++) if (regs[k*RW +: RW] !== exp_regs[k]) bad++;
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_cyc   = cyc;
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  function automatic int first_tx();
    return (txc.size() > 0) ? txc[0] : -1;
  endfunction

  // Compare captured tx bytes against expq (plus checksum when enabled), then clear.
  task automatic check_resp(input string tag);
    logic [7:0]  x;
    logic [63:0] a;
    int          ne;
    x  = 8'h00;
    ne = expq.size();
`ifdef SERIAL_CMD_CHECKSUM_EN
    check_eq({tag, "_len"}, 64'(txq.size()), 64'(ne + 1));
`else
    check_eq({tag, "_len"}, 64'(txq.size()), 64'(ne));
`endif
    for (int i = 0; i < ne; i++) begin
      x ^= expq[i];
      a = (i < txq.size()) ? 64'(txq[i]) : 64'hFFFF;
      check_eq($sformatf("%s_b%0d", tag, i), a, 64'(expq[i]));
    end
`ifdef SERIAL_CMD_CHECKSUM_EN
    a = (ne < txq.size()) ? 64'(txq[ne]) : 64'hFFFF;
    check_eq({tag, "_csum"}, a, 64'(x));
`endif
    txq.delete();
    txc.delete();
    expq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < NR; k++) exp_regs[k] = INIT[k*RW +: RW];

    // Reset state
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_txs", 64'(tx_start), 64'd0);
    check_eq("rst_err", 64'(err_count), 64'd0);
    check_eq("rst_pulse", 64'(pulse_out), 64'd0);
    check_eq("rst_hrst", 64'(hist_reset), 64'd0);
    check_regs("rst_regs");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Version read, with first-byte latency
    send_byte(8'h00);
    wait_idle("ver");
    check_eq("ver_lat", 64'(first_tx()), 64'(rx_cyc + 1));
    expq = '{8'h08};
    check_resp("ver");
    check_regs("ver_regs");

    // Register write then read back
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h78);
    send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    wait_idle("wr3");
    exp_regs[3] = 32'h1234_5678;
    check_regs("wr3_regs");
    check_eq("wr3_notx", 64'(txq.size()), 64'd0);
    send_byte(8'h02); send_byte(8'h03);
    wait_idle("rd3");
    expq = '{8'h78, 8'h56, 8'h34, 8'h12};
    check_resp("rd3");
    check_eq("rd3_err", 64'(err_count), 64'd0);

    // Out-of-range address for write and read
    send_byte(8'h01); send_byte(8'h20); send_byte(8'hDE);
    send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_idle("wrbad");
    check_regs("wrbad_regs");
    check_eq("wrbad_err", 64'(err_count), 64'd1);
    send_byte(8'h02); send_byte(8'h20);
    wait_idle("rdbad");
    expq = '{8'h00, 8'h00, 8'h00, 8'h00};
    check_resp("rdbad");
    check_eq("rdbad_err", 64'(err_count), 64'd2);

    // Histogram snapshot with a slow transmitter and post-snapshot count changes
    histos    = '0;
    histos[31:0] = 32'h0000_00AA;
    hr_n      = 0;
    busy_mode = 1'b1;
    send_byte(8'h03);
    repeat (5) @(negedge clk);
    histos = '1;
    wait_idle("hist");
    busy_mode = 1'b0;
    histos    = '0;
    check_eq("hist_hrst_n", 64'(hr_n), 64'd1);
    check_eq("hist_hrst_cyc", 64'(hr_cyc), 64'(rx_cyc + 1));
    check_eq("hist_lat", 64'(first_tx()), 64'(rx_cyc + 2));
    expq.push_back(8'hAA);
    for (int i = 1; i < NH * HW / 8; i++) expq.push_back(8'h00);
    check_resp("hist");
    check_eq("hist_err", 64'(err_count), 64'd2);

    // Inter-byte timeout
    send_byte(8'h01);
    repeat (95) @(negedge clk);
    check_eq("tmo_busy_hi", 64'(busy), 64'd1);
    repeat (10) @(negedge clk);
    check_eq("tmo_busy_lo", 64'(busy), 64'd0);
    check_eq("tmo_err", 64'(err_count), 64'd3);
    check_eq("tmo_notx", 64'(txq.size()), 64'd0);
    check_regs("tmo_regs");
    send_byte(8'h00);
    wait_idle("ver2");
    expq = '{8'h08};
    check_resp("ver2");

    // User pulse
    pl_n = 0;
    send_byte(8'h04); send_byte(8'h81);
    wait_idle("pulse");
    repeat (3) @(negedge clk);
    check_eq("pulse_n", 64'(pl_n), 64'd1);
    check_eq("pulse_val", 64'(pl_val), 64'h81);
    check_eq("pulse_err", 64'(err_count), 64'd3);

    // Unknown opcode
    send_byte(8'h7E);
    wait_idle("badop");
    check_eq("badop_err", 64'(err_count), 64'd4);
    check_eq("badop_notx", 64'(txq.size()), 64'd0);

    // Byte arriving while a response is going out is dropped
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h55);
    wait_idle("rxsend");
    expq = '{8'h78, 8'h56, 8'h34, 8'h12};
    check_resp("rxsend");
    check_eq("rxsend_err", 64'(err_count), 64'd5);

    // Reset in the middle of a write
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    #3 rstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NR; k++) exp_regs[k] = INIT[k*RW +: RW];
    check_eq("mrst_busy", 64'(busy), 64'd0);
    check_eq("mrst_err", 64'(err_count), 64'd0);
    check_regs("mrst_regs");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("mrst_notx", 64'(txq.size()), 64'd0);
    check_regs("mrst_regs2");
    send_byte(8'h00);
    wait_idle("ver3");
    expq = '{8'h08};
    check_resp("ver3");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
